// File: rtl/md_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation codes,
// FSM state encodings and the fixed start-to-idle cycle count.
package md_unit_pkg;

    localparam int MD_WIDTH  = 32;
    localparam int MD_CYCLES = 34;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    localparam logic [1:0] MD_ST_IDLE  = 2'd0;
    localparam logic [1:0] MD_ST_CALC  = 2'd1;
    localparam logic [1:0] MD_ST_FIXUP = 2'd2;
    localparam logic [1:0] MD_ST_DONE  = 2'd3;

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the pipeline (master) and md_unit (slave).
interface md_unit_if
    import md_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic             div_zero_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, flush_i,
        input  busy_o, done_o, div_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, flush_i,
        output busy_o, done_o, div_zero_o, hi_o, lo_o
    );
endinterface

// File: rtl/md_unit_signfix.sv
// Combinational two's-complement negate on a 2*WIDTH value, either as one
// wide number (split=0, controlled by neg_lo) or as two independent halves.
module md_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] val,
    input  logic               split,
    input  logic               neg_hi,
    input  logic               neg_lo,
    output logic [2*WIDTH-1:0] res
);
    logic [WIDTH-1:0] v_hi;
    logic [WIDTH-1:0] v_lo;

    assign v_hi = val[2*WIDTH-1:WIDTH];
    assign v_lo = val[WIDTH-1:0];

    always_comb begin
        if (split) begin
            res = {(neg_hi ? -v_hi : v_hi), (neg_lo ? -v_lo : v_lo)};
        end else begin
            res = neg_lo ? -val : val;
        end
    end
endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: 34 cycles from accepted start to idle,
// done pulses in the last one; busy stalls the pipeline and further starts are dropped.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic     clk_i,
    input  logic     rst_i,
    md_unit_if.slave md
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic               div_zero_pend;
    logic [WIDTH-1:0]   sh;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   rs_raw;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               div_zero;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mags;
    logic [2*WIDTH-1:0] fixed;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               op_div;
    logic               op_signed;
    logic               in_neg_a;
    logic               in_neg_b;

    assign op_div    = (md.op_i == MD_OP_DIV) || (md.op_i == MD_OP_DIVU);
    assign op_signed = (md.op_i == MD_OP_MULT) || (md.op_i == MD_OP_DIV);
    assign in_neg_a  = op_signed & md.rs_i[WIDTH-1];
    assign in_neg_b  = op_signed & md.rt_i[WIDTH-1];

    md_signfix #(.WIDTH(WIDTH)) u_operand_fix (
        .val    ({md.rs_i, md.rt_i}),
        .split  (1'b1),
        .neg_hi (in_neg_a),
        .neg_lo (in_neg_b),
        .res    (mags)
    );

    // Divide keeps remainder/quotient as separate halves; multiply negates the whole product.
    md_signfix #(.WIDTH(WIDTH)) u_result_fix (
        .val    (acc),
        .split  (is_div),
        .neg_hi (neg_a),
        .neg_lo (neg_a ^ neg_b),
        .res    (fixed)
    );

    // sh feeds bits MSB-first: multiplier bits for shift-add, dividend bits for restoring divide.
    always_comb begin
        rem_sh  = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        if (is_div) begin
            if (!rem_sub[WIDTH]) begin
                acc_nxt = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0} + (sh[WIDTH-1] ? {{WIDTH{1'b0}}, dvs} : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= MD_ST_IDLE;
            cnt           <= '0;
            is_div        <= 1'b0;
            neg_a         <= 1'b0;
            neg_b         <= 1'b0;
            div_zero_pend <= 1'b0;
            sh            <= '0;
            dvs           <= '0;
            rs_raw        <= '0;
            acc           <= '0;
            hi            <= '0;
            lo            <= '0;
            div_zero      <= 1'b0;
        end else begin
            case (state)
                MD_ST_IDLE: begin
                    if (md.start_i) begin
                        is_div        <= op_div;
                        neg_a         <= in_neg_a;
                        neg_b         <= in_neg_b;
                        div_zero_pend <= op_div && (md.rt_i == '0);
                        sh            <= mags[2*WIDTH-1:WIDTH];
                        dvs           <= mags[WIDTH-1:0];
                        rs_raw        <= md.rs_i;
                        acc           <= '0;
                        cnt           <= '0;
                        state         <= MD_ST_CALC;
                    end
                end
                MD_ST_CALC: begin
                    if (md.flush_i) begin
                        state <= MD_ST_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        sh  <= {sh[WIDTH-2:0], 1'b0};
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= MD_ST_FIXUP;
                        end
                    end
                end
                MD_ST_FIXUP: begin
                    if (md.flush_i) begin
                        state <= MD_ST_IDLE;
                    end else begin
                        if (div_zero_pend) begin
                            hi <= rs_raw;
                            lo <= '1;
                        end else begin
                            hi <= fixed[2*WIDTH-1:WIDTH];
                            lo <= fixed[WIDTH-1:0];
                        end
                        div_zero <= div_zero_pend;
                        state    <= MD_ST_DONE;
                    end
                end
                default: state <= MD_ST_IDLE;
            endcase
        end
    end

    assign md.busy_o     = (state != MD_ST_IDLE);
    assign md.done_o     = (state == MD_ST_DONE);
    assign md.div_zero_o = div_zero;
    assign md.hi_o       = hi;
    assign md.lo_o       = lo;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed corner cases plus random ops, checked against
// a 64-bit arithmetic reference model.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    md_unit_if #(.WIDTH(32)) bus ();

    md_unit #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .md    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        dz = 1'b0;
        sa = 0;
        sb = 0;
        q  = 0;
        r  = 0;
        p  = '0;
        if (op == MD_OP_MULT) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
        end else if (op == MD_OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
        end else if (b == 32'b0) begin
            dz = 1'b1;
            p  = {a, 32'hFFFF_FFFF};
        end else begin
            if (op == MD_OP_DIV) begin
                sa = $signed(a);
                sb = $signed(b);
            end else begin
                sa = longint'({32'b0, a});
                sb = longint'({32'b0, b});
            end
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
        int          k;
        int          busy_n;
        model(op, a, b, ehi, elo, edz);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs_i    = a;
        bus.rt_i    = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.op_i    = 2'($urandom);
        bus.rs_i    = $urandom;
        bus.rt_i    = $urandom;
        k      = 0;
        busy_n = 0;
        while (bus.done_o !== 1'b1 && k < 60) begin
            if (bus.busy_o === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            k++;
        end
        if (bus.busy_o === 1'b1) busy_n++;
        check({tag, "/done_at"}, 64'(k), 64'(MD_CYCLES - 1));
        check({tag, "/hi"}, bus.hi_o, ehi);
        check({tag, "/lo"}, bus.lo_o, elo);
        check({tag, "/div_zero"}, bus.div_zero_o, edz);
        @(posedge clk);
        #1;
        check({tag, "/done_pulse"}, {bus.done_o, bus.busy_o}, 2'b00);
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'(MD_CYCLES));
    endtask

    initial begin
        int          dones;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start_i = 1'b0;
        bus.op_i    = MD_OP_MULT;
        bus.rs_i    = '0;
        bus.rt_i    = '0;
        bus.flush_i = 1'b0;

        #2 rst = 1'b1;
        #2;
        check("reset/hi_lo", {bus.hi_o, bus.lo_o}, 64'h0);
        check("reset/flags", {bus.busy_o, bus.done_o, bus.div_zero_o}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mult_neg3x5", MD_OP_MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg3x5/const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu_max", MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max/const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg7by2", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7by2/const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf/const", {bus.hi_o, bus.lo_o}, 64'h0000_0000_8000_0000);
        run_op("divu_by0", MD_OP_DIVU, 32'd100, 32'd0);
        check("divu_by0/const", {bus.div_zero_o, bus.hi_o, bus.lo_o}, {1'b1, 64'h0000_0064_FFFF_FFFF});
        run_op("multu_2x3", MD_OP_MULTU, 32'd2, 32'd3);
        check("multu_2x3/const", {bus.div_zero_o, bus.hi_o, bus.lo_o}, {1'b0, 64'h0000_0000_0000_0006});

        // Flush in CALC at E10: no completion, HI/LO untouched.
        bus.start_i = 1'b1;
        bus.op_i    = MD_OP_DIVU;
        bus.rs_i    = 32'd9;
        bus.rt_i    = 32'd4;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_calc/flags", {bus.busy_o, bus.done_o}, 2'b00);
        check("flush_calc/hi_lo", {bus.hi_o, bus.lo_o}, 64'h0000_0000_0000_0006);

        // Restart with flush and start together; a stray start at E5 must be dropped.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("start_with_flush/busy", bus.busy_o, 1'b1);
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            bus.start_i = (k == 5);
            if (k == 5) begin
                bus.op_i = MD_OP_MULT;
                bus.rs_i = 32'd7;
                bus.rt_i = 32'd7;
            end
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1) dones++;
        end
        bus.start_i = 1'b0;
        check("ignored_start/done_count", 64'(dones), 64'd1);
        check("ignored_start/hi_lo", {bus.hi_o, bus.lo_o}, 64'h0000_0001_0000_0002);

        // Flush while in FIXUP (sampled at E33): no write, no done.
        bus.start_i = 1'b1;
        bus.op_i    = MD_OP_MULTU;
        bus.rs_i    = 32'h1234;
        bus.rt_i    = 32'h10;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_fixup/flags", {bus.busy_o, bus.done_o}, 2'b00);
        check("flush_fixup/hi_lo", {bus.hi_o, bus.lo_o}, 64'h0000_0001_0000_0002);

        // Reset at E15 of a MULT clears everything immediately.
        bus.start_i = 1'b1;
        bus.op_i    = MD_OP_MULT;
        bus.rs_i    = 32'h1234_5678;
        bus.rt_i    = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_reset/hi_lo", {bus.hi_o, bus.lo_o}, 64'h0);
        check("mid_reset/flags", {bus.busy_o, bus.done_o, bus.div_zero_o}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset/busy", bus.busy_o, 1'b0);
        run_op("post_reset_mult", MD_OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'h0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
